// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per clock LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bout
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-1:0]  res;
  logic          borrow;
  logic [CW-1:0] cnt;
  logic          d_bit;
  logic          b_next;

  // One full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fsub(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

  assign {b_next, d_bit} = fsub(sa[0], sb[0], borrow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= A;
            sb     <= B;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Result register fills from the MSB so bit 0 ends at res[0].
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= {d_bit, res[N-1:1]};
          borrow <= b_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            D     <= {d_bit, res[N-1:1]};
            Bout  <= b_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at N=8 and N=4.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] d8;
  logic       bout8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4;
  logic       done4;
  logic [3:0] d4;
  logic       bout4;

  int checks = 0;
  int fails  = 0;

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
  );

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one N=8 operation and check latency, busy window and result.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] expd, input logic expb);
    int cyc;
    int bcnt;
    int both;
    a8 = a; b8 = b; start8 = 1'b1;
    cyc = 0; bcnt = 0; both = 0;
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (busy8) bcnt++;
      if (busy8 && done8) both++;
    end
    chk({tag, "_latency"}, cyc, 9);
    chk({tag, "_busycycles"}, bcnt, 8);
    chk({tag, "_overlap"}, both, 0);
    chk({tag, "_D"}, d8, expd);
    chk({tag, "_Bout"}, bout8, expb);
    @(negedge clk);
    chk({tag, "_donefall"}, {busy8, done8}, 2'b00);
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b);
    int cyc;
    logic [3:0] expd;
    expd = a - b;
    a4 = a; b4 = b; start4 = 1'b1;
    cyc = 0;
    while (!done4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
    end
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_D"}, d4, expd);
    chk({tag, "_Bout"}, bout4, (a < b) ? 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int dn;
    int last;
    logic [7:0] hold_d;
    logic       hold_b;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst8", {busy8, done8, bout8, d8}, 11'h0);
    chk("rst4", {busy4, done4, bout4, d4}, 7'h0);
    reset = 1'b0;
    @(negedge clk);

    op8("s100m37", 8'd100, 8'd37, 8'd63, 1'b0);
    op8("s0m1", 8'h00, 8'h01, 8'hFF, 1'b1);
    op8("sA5mA5", 8'hA5, 8'hA5, 8'h00, 1'b0);
    op8("sFFm0", 8'hFF, 8'h00, 8'hFF, 1'b0);
    op8("s80m7F", 8'h80, 8'h7F, 8'h01, 1'b0);

    // start pulse and operand changes during RUN are ignored
    a8 = 8'd200; b8 = 8'd50; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = 8'h33; b8 = 8'h44;
    cyc = 4;
    while (!done8 && cyc < 30) begin @(negedge clk); cyc++; end
    chk("ign_latency", cyc, 9);
    chk("ign_D", d8, 8'd150);
    chk("ign_Bout", bout8, 1'b0);
    dn = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) dn++; end
    chk("ign_noextra", dn, 0);

    // asynchronous reset mid-RUN
    a8 = 8'd77; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_busy_before", busy8, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstmid_outs", {busy8, done8, bout8, d8}, 11'h0);
    @(negedge clk); reset = 1'b0;
    dn = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) dn++; end
    chk("rstmid_nodone", dn, 0);
    chk("rstmid_D_hold", d8, 8'h00);
    op8("s9m3", 8'd9, 8'd3, 8'd6, 1'b0);

    // start held high: back-to-back operations every N+2 cycles
    a8 = 8'd5; b8 = 8'd7; start8 = 1'b1;
    cyc = 0; last = -1;
    for (int p = 0; p < 3; p++) begin
      dn = 0;
      while (!done8 && dn < 30) begin @(negedge clk); cyc++; dn++; end
      chk($sformatf("held%0d_D", p), d8, 8'hFE);
      chk($sformatf("held%0d_Bout", p), bout8, 1'b1);
      if (last >= 0) chk($sformatf("held%0d_spacing", p), cyc - last, 10);
      last = cyc;
      hold_d = d8; hold_b = bout8;
      if (p == 2) start8 = 1'b0;
      @(negedge clk); cyc++;
      dn = 0;
      while (!done8 && dn < 8) begin
        if (d8 !== hold_d || bout8 !== hold_b) dn = 100;
        else dn++;
        if (!done8 && dn < 8) begin @(negedge clk); cyc++; end
      end
      chk($sformatf("held%0d_stable", p), (dn >= 100) ? 1 : 0, 0);
    end
    dn = 0;
    repeat (14) begin @(negedge clk); if (done8) dn++; end
    chk("held_stop", dn, 0);

    // N=4 instance
    op4("n4_3m4", 4'd3, 4'd4);
    chk("n4_3m4_Dexact", d4, 4'hF);
    for (int i = 0; i < 12; i++) begin
      op4($sformatf("n4_rnd%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing D = A − B one bit per clock, LSB first, with a single full-subtractor cell and a registered borrow. It is the inverse companion of the lab's gate-level adder blocks and sits behind the same operand switches and LED result display. A start/busy/done handshake frames each operation. The result and final borrow are held until the next operation completes.

## Interface
- N, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; forces all state and outputs to reset values immediately.
- start  input  1  request a new subtraction; sampled only in IDLE.
- A  input  N  minuend, captured on the accepting edge.
- B  input  N  subtrahend, captured on the accepting edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when D/Bout have just been updated.
- D  output  N  difference A − B mod 2^N.
- Bout  output  1  final borrow; 1 iff A < B (unsigned).

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: if start=1 at the edge → load shift regs SA<=A, SB<=B, borrow<=0, bit counter<=0, go RUN. Else stay.
- RUN, per edge: a=SA[0], b=SB[0], bin=borrow.
  - d = a ^ b ^ bin
  - bnext = (~a & b) | (~(a ^ b) & bin)
  - SA, SB shift right one; d shifted into result shift reg at MSB (result reg shifts right); borrow<=bnext; counter++.
  - On the edge processing bit N−1: D<=completed result (incl. that bit), Bout<=bnext, go DONE.
- DONE: done=1 for exactly this cycle; next edge → IDLE unconditionally.
- start ignored in RUN and DONE (no queueing); A/B changes after acceptance have no effect.
- D and Bout change only on the final RUN edge; otherwise hold previous values.
- Counter width ceil(log2(N)); no arithmetic beyond 1-bit full-subtractor cell; D wraps modulo 2^N.

## Timing
- Reset values: busy=0, done=0, D=0, Bout=0, state IDLE, internal regs 0.
- Accepting edge E0 (start=1 in IDLE). busy=1 from after E0 through E_N; edges E1..EN process bits 0..N−1.
- After E_N: D/Bout valid, busy=0, done=1 for one cycle; after E_{N+1}: done=0, IDLE.
- Latency start-accept to done: N+1 cycles; minimum start-to-start spacing N+2 cycles.
- busy and done never high together; both are registered (state-decoded, no combinational path from inputs).
- reset asserted mid-RUN or in DONE: abort, no done pulse, outputs to reset values; after release, IDLE awaiting start.
- start held high continuously: new operation accepted each time IDLE is reached (every N+2 cycles).

## Test plan
- Reset, then A=100, B=37, start one cycle → busy 8 cycles, done pulse at cycle 9 after accept, D=63, Bout=0.
- A=0, B=1 → D=0xFF, Bout=1; A=0xA5, B=0xA5 → D=0x00, Bout=0; A=0xFF, B=0x00 → D=0xFF, Bout=0.
- During RUN of A=200,B=50, pulse start with A=1,B=2 and change A/B → ignored; D=150, Bout=0, single done pulse.
- Assert reset at cycle 4 of RUN → busy=0, done=0, D=0, Bout=0 immediately; no done follows; next op A=9,B=3 → D=6.
- start held high with A=5,B=7 → done every 10 cycles, each D=0xFE, Bout=1; D/Bout stable between pulses.
- N=4 instance: A=3, B=4 → done after 5 cycles, D=0xF, Bout=1; random sweep vs. reference model (A−B) mod 2^N, borrow=A<B.
